// File: rtl/ps2_host_tx.sv
// ps2_host_tx - PS/2 host-to-device transmitter.
//
// Sends one command byte to a PS/2 device (e.g. keyboard LED set 0xED, reset 0xFF,
// typematic 0xF3). Shares the open-drain ps2 clock/data pins with the receiver block
// and only ever pulls them low through output enables.
// Frame: inhibit clock, request-to-send (data low, release clock), then on each
// device falling clock edge shift out 8 data bits LSB first, odd parity and stop.
// The 11th falling edge samples the device ACK. A timeout covers the whole
// device-clocked part of the transaction.
//
// Optional feature macro: PS2TX_RETRY_EN
//   defined   : a NACK or timeout retransmits the held byte from INHIBIT up to two
//               more times; error pulses only after the third failure.
//   undefined : the first NACK/timeout pulses error and returns to IDLE.
//
// Ports
//   clock     in   system clock
//   reset     in   asynchronous, active-low reset
//   ce        in   clock enable (8 MHz); all state advances only when ce=1
//   ps2ClkI   in   PS/2 clock pin level
//   ps2DatI   in   PS/2 data pin level
//   ps2ClkOe  out  1 = pull PS/2 clock low, 0 = release
//   ps2DatOe  out  1 = pull PS/2 data low, 0 = release
//   start     in   request to send di (sampled when ce=1, honoured only in IDLE)
//   di        in   byte to send, captured on accepted start
//   busy      out  1 from accepted start until return to IDLE
//   done      out  one-ce-cycle pulse: byte sent and ACKed
//   error     out  one-ce-cycle pulse: NACK or timeout
module ps2_host_tx #(
  parameter int INHIBIT_CYC = 800,
  parameter int TIMEOUT_CYC = 120000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ce,
  input  logic       ps2ClkI,
  input  logic       ps2DatI,
  output logic       ps2ClkOe,
  output logic       ps2DatOe,
  input  logic       start,
  input  logic [7:0] di,
  output logic       busy,
  output logic       done,
  output logic       error
);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SEND,
    ACK,
    WAITIDLE
  } state_t;

  localparam logic [16:0] INH_LAST = 17'(INHIBIT_CYC - 1);
  localparam logic [16:0] TO_LAST  = 17'(TIMEOUT_CYC - 1);

  state_t      state, state_d;
  logic        clk_s1, clk_s2, clk_prev;
  logic        dat_s1, dat_s2;
  logic        fall;
  logic [16:0] cnt, cnt_d;
  logic [3:0]  bitcnt, bitcnt_d;
  logic [9:0]  sh, sh_d;     // {stop, parity, data}; bits still to be sent
  logic        cur, cur_d;   // bit currently on the data line (start bit = 0)
  logic        done_d, error_d;
  logic        fail;
`ifdef PS2TX_RETRY_EN
  logic [7:0]  data, data_d; // held byte for retransmission
  logic [1:0]  retry, retry_d;
`endif

  // Pin synchroniser, advanced on ce only. Idle bus level is high, so reset the
  // stages to 1 to avoid a phantom falling edge coming out of reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
    end else if (ce) begin
      clk_s1   <= ps2ClkI;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      dat_s1   <= ps2DatI;
      dat_s2   <= dat_s1;
    end
  end

  assign fall = clk_prev & ~clk_s2;
  assign busy = (state != IDLE);

  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d  = state;
    cnt_d    = cnt;
    bitcnt_d = bitcnt;
    sh_d     = sh;
    cur_d    = cur;
    done_d   = 1'b0;
    error_d  = 1'b0;
    fail     = 1'b0;
    ps2ClkOe = 1'b0;
    ps2DatOe = 1'b0;
`ifdef PS2TX_RETRY_EN
    data_d   = data;
    retry_d  = retry;
`endif

    case (state)
      IDLE: begin
        if (start) begin
          sh_d     = {1'b1, ~^di, di};
          cur_d    = 1'b0;
          cnt_d    = '0;
          bitcnt_d = '0;
          state_d  = INHIBIT;
`ifdef PS2TX_RETRY_EN
          data_d   = di;
          retry_d  = '0;
`endif
        end
      end
      INHIBIT: begin
        ps2ClkOe = 1'b1;
        if (cnt == INH_LAST) begin
          cnt_d   = '0;
          state_d = REQ;
        end else begin
          cnt_d = cnt + 17'd1;
        end
      end
      REQ: begin
        // Data goes low while clock is still held; clock is released one ce later.
        ps2ClkOe = 1'b1;
        ps2DatOe = 1'b1;
        cnt_d    = '0;
        bitcnt_d = '0;
        state_d  = SEND;
      end
      SEND: begin
        ps2DatOe = ~cur;
        if (fall) begin
          bitcnt_d = bitcnt + 4'd1;
          cur_d    = sh[0];
          sh_d     = {1'b1, sh[9:1]};
          if (bitcnt == 4'd9) state_d = ACK;
        end
      end
      ACK: begin
        if (fall) begin
          if (!dat_s2) state_d = WAITIDLE;
          else         fail    = 1'b1;
        end
      end
      WAITIDLE: begin
        if (clk_s2 && dat_s2) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Transaction timeout over the device-clocked phases.
    if (state inside {SEND, ACK, WAITIDLE}) begin
      if (cnt == TO_LAST) fail = 1'b1;
      else                cnt_d = cnt + 17'd1;
    end

    // A failure overrides everything else, so done and error can never coincide.
    if (fail) begin
      done_d = 1'b0;
`ifdef PS2TX_RETRY_EN
      if (retry != 2'd2) begin
        retry_d  = retry + 2'd1;
        sh_d     = {1'b1, ~^data, data};
        cur_d    = 1'b0;
        cnt_d    = '0;
        bitcnt_d = '0;
        state_d  = INHIBIT;
      end else begin
        error_d = 1'b1;
        state_d = IDLE;
      end
`else
      error_d = 1'b1;
      state_d = IDLE;
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      bitcnt <= '0;
      sh     <= '0;
      cur    <= 1'b0;
      done   <= 1'b0;
      error  <= 1'b0;
`ifdef PS2TX_RETRY_EN
      data   <= '0;
      retry  <= '0;
`endif
    end else if (ce) begin
      state  <= state_d;
      cnt    <= cnt_d;
      bitcnt <= bitcnt_d;
      sh     <= sh_d;
      cur    <= cur_d;
      done   <= done_d;
      error  <= error_d;
`ifdef PS2TX_RETRY_EN
      data   <= data_d;
      retry  <= retry_d;
`endif
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Testbench for ps2_host_tx: a PS/2 device model clocks frames out of the host,
// a scoreboard holds the expected frame for each transmission, and pulse monitors
// count done/error rising edges.
module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int TO  = 3000;
  localparam int H   = 30;   // device clock half period, in system clocks
`ifdef PS2TX_RETRY_EN
  localparam int NFR = 3;
`else
  localparam int NFR = 1;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       ce = 1'b0;
  logic       start = 1'b0;
  logic [7:0] di = 8'h00;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       clk_line, dat_line;
  logic       ps2ClkOe, ps2DatOe, busy, done, error;

  int compared = 0;
  int mismatched = 0;
  int done_cnt = 0;
  int error_cnt = 0;
  int both_cnt = 0;
  int ce_edges = 0;
  logic done_p = 1'b0;
  logic error_p = 1'b0;
  logic [10:0] sb[$];

  assign clk_line = ps2ClkOe ? 1'b0 : dev_clk;
  assign dat_line = ps2DatOe ? 1'b0 : dev_dat;

  ps2_host_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TO)) dut (
    .clock(clock), .reset(reset), .ce(ce),
    .ps2ClkI(clk_line), .ps2DatI(dat_line),
    .ps2ClkOe(ps2ClkOe), .ps2DatOe(ps2DatOe),
    .start(start), .di(di),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clock = ~clock;
  always @(negedge clock) ce = ~ce;
  always @(posedge clock) if (ce) ce_edges++;

  always @(negedge clock) begin
    if (done && !done_p) done_cnt++;
    if (error && !error_p) error_cnt++;
    if (done && error) both_cnt++;
    done_p  = done;
    error_p = error;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Frame as seen on the wire: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] mk_frame(input logic [7:0] d);
    logic p;
    p = ($countones(d) % 2 == 0);
    return {1'b1, p, d, 1'b0};
  endfunction

  task automatic send(input logic [7:0] d);
    int g;
    @(negedge clock);
    start = 1'b1;
    di = d;
    g = 0;
    while (!busy && g < 20) begin @(negedge clock); g++; end
    start = 1'b0;
    check("busy after start", busy, 1'b1);
  endtask

  // Device side: wait for request-to-send, then generate nedges falling clock
  // edges, sampling the data line during each high phase. Edge 11 carries the ACK.
  task automatic device_frame(input bit ack, input int nedges,
                              output logic [10:0] bits, output bit ok);
    int g;
    bits = '0;
    ok = 1'b0;
    g = 0;
    while (!(ps2ClkOe == 1'b0 && ps2DatOe == 1'b1) && g < 4000) begin
      @(negedge clock); g++;
    end
    if (g >= 4000) return;
    ok = 1'b1;
    bits[0] = dat_line;
    for (int k = 1; k <= 10 && k <= nedges; k++) begin
      wait_clk(H / 2);
      dev_clk = 1'b0;
      wait_clk(H);
      dev_clk = 1'b1;
      wait_clk(H / 2);
      bits[k] = dat_line;
    end
    if (nedges >= 11) begin
      wait_clk(4);
      if (ack) dev_dat = 1'b0;
      wait_clk(4);
      dev_clk = 1'b0;
      wait_clk(H);
      dev_clk = 1'b1;
      wait_clk(H);
      dev_dat = 1'b1;
    end
  endtask

  task automatic frame_check(input string tag, input logic [10:0] bits, input bit ok);
    logic [10:0] exp;
    check({tag, " request seen"}, ok, 1'b1);
    check({tag, " scoreboard entry"}, sb.size() > 0, 1'b1);
    if (sb.size() > 0) begin
      exp = sb.pop_front();
      check({tag, " frame bits"}, bits, exp);
    end
  endtask

  task automatic wait_done(input int d0);
    int g;
    g = 0;
    while (done_cnt == d0 && g < 300) begin @(negedge clock); g++; end
  endtask

  task automatic wait_error(input int e0);
    int g;
    g = 0;
    while (error_cnt == e0 && g < 300) begin @(negedge clock); g++; end
  endtask

  // One full ACKed transfer with scoreboard and pulse checks.
  task automatic good_tx(input string tag, input logic [7:0] d, output logic [10:0] bits);
    bit ok;
    int d0, e0;
    d0 = done_cnt;
    e0 = error_cnt;
    sb.push_back(mk_frame(d));
    send(d);
    device_frame(1'b1, 11, bits, ok);
    frame_check(tag, bits, ok);
    wait_done(d0);
    wait_clk(4);
    check({tag, " done once"}, done_cnt, d0 + 1);
    check({tag, " no error"}, error_cnt, e0);
    check({tag, " busy low"}, busy, 1'b0);
  endtask

  initial begin
    logic [10:0] bits;
    bit ok;
    int d0, e0, g, t0;

    // Reset state
    wait_clk(3);
    #1;
    check("reset clk oe", ps2ClkOe, 1'b0);
    check("reset dat oe", ps2DatOe, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset error", error, 1'b0);
    reset = 1'b1;
    wait_clk(6);

    // 1: LED command byte
    good_tx("tx ED", 8'hED, bits);
    check("tx ED data bits", {23'd0, bits[8:0]}, 32'b1_1101_1010);

    // 2: parity boundary cases
    good_tx("tx 00", 8'h00, bits);
    check("parity 00", bits[9], 1'b1);
    good_tx("tx FF", 8'hFF, bits);
    check("parity FF", bits[9], 1'b1);
    good_tx("tx 01", 8'h01, bits);
    check("parity 01", bits[9], 1'b0);

    // 3: device NACK
    d0 = done_cnt;
    e0 = error_cnt;
    send(8'hF3);
    for (int a = 0; a < NFR; a++) begin
      sb.push_back(mk_frame(8'hF3));
      device_frame(1'b0, 11, bits, ok);
      frame_check("nack", bits, ok);
      if (a < NFR - 1) begin
        wait_clk(10);
        check("nack retry busy", busy, 1'b1);
        check("nack retry no error", error_cnt, e0);
      end
    end
    wait_error(e0);
    wait_clk(4);
    check("nack error once", error_cnt, e0 + 1);
    check("nack no done", done_cnt, d0);
    check("nack clk oe", ps2ClkOe, 1'b0);
    check("nack dat oe", ps2DatOe, 1'b0);
    check("nack busy", busy, 1'b0);

    // 4: device never clocks -> timeout measured in ce cycles from clock release
    d0 = done_cnt;
    e0 = error_cnt;
    send(8'hFF);
    for (int a = 0; a < NFR; a++) begin
      g = 0;
      while (!(ps2ClkOe == 1'b0 && ps2DatOe == 1'b1) && g < 4000) begin
        @(negedge clock); g++;
      end
      check("timeout release seen", g < 4000, 1'b1);
      t0 = ce_edges;
      g = 0;
      if (a < NFR - 1) begin
        while (ps2ClkOe == 1'b0 && g < 4 * TO) begin @(negedge clock); g++; end
        check("timeout retry interval", ce_edges - t0, TO);
      end else begin
        while (error_cnt == e0 && g < 4 * TO) begin @(negedge clock); g++; end
        check("timeout interval", ce_edges - t0, TO);
      end
    end
    check("timeout error once", error_cnt, e0 + 1);
    check("timeout clk oe", ps2ClkOe, 1'b0);
    check("timeout dat oe", ps2DatOe, 1'b0);
    check("timeout busy", busy, 1'b0);
    check("timeout no done", done_cnt, d0);

    // 5: reset after the 4th bit, then a clean transfer
    d0 = done_cnt;
    e0 = error_cnt;
    send(8'h5A);
    device_frame(1'b1, 4, bits, ok);
    check("partial request seen", ok, 1'b1);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("midreset clk oe", ps2ClkOe, 1'b0);
    check("midreset dat oe", ps2DatOe, 1'b0);
    check("midreset busy", busy, 1'b0);
    wait_clk(4);
    reset = 1'b1;
    wait_clk(20);
    check("midreset no done", done_cnt, d0);
    check("midreset no error", error_cnt, e0);
    good_tx("tx after reset", 8'hF3, bits);

    // 6: start while busy is ignored
    d0 = done_cnt;
    sb.push_back(mk_frame(8'h0F));
    send(8'h0F);
    @(negedge clock);
    start = 1'b1;
    di = 8'hFF;
    wait_clk(4);
    start = 1'b0;
    di = 8'h00;
    device_frame(1'b1, 11, bits, ok);
    frame_check("busy start", bits, ok);
    wait_done(d0);
    wait_clk(200);
    check("busy start one done", done_cnt, d0 + 1);
    check("busy start idle", busy, 1'b0);
    check("busy start no new frame", ps2ClkOe, 1'b0);
    check("scoreboard drained", sb.size(), 0);
    check("done/error never together", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
